serial_nibble_rx: RTL and testbench

Serial front end that receives framed 4-bit values on a single-wire input and presents each accepted nibble as a parallel word plus a one-cycle load strobe. It sits directly upstream of the team's 4-bit D register: `D` drives the register's data input, and `ld` gates its capture. Frames with bad parity, a bad stop bit or a stall are rejected without disturbing `D`.

---
 rtl/serial_nibble_rx_if.sv | 24 ++
 rtl/serial_nibble_rx.sv | 116 +++++++++++
 tb/tb_serial_nibble_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/serial_nibble_rx_if.sv
// Bundles the serial strobe/data inputs and the parallel nibble outputs.
// Latency: none, signal container only.
// Backpressure: none; bit_en is a free-running strobe that cannot be stalled.
interface serial_nibble_rx_if;
  logic       bit_en;
  logic       sin;
  logic [3:0] D;
  logic       ld;
  logic       busy;
  logic       perr;
  logic       ferr;

  // Serial source side: drives the line, observes the receiver.
  modport master (
    output bit_en, sin,
    input  D, ld, busy, perr, ferr
  );

  // Receiver side.
  modport slave (
    input  bit_en, sin,
    output D, ld, busy, perr, ferr
  );
endinterface

// File: rtl/serial_nibble_rx.sv
// Receives start/4 data/even parity/stop frames and presents accepted nibbles on D with a one-cycle ld.
// Latency: D and ld update on the edge that samples the stop bit; all outputs are registered.
// Backpressure: none; frames are paced by bit_en only, and a stalled frame is dropped after TIMEOUT idle edges.
module serial_nibble_rx #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  serial_nibble_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  // The timeout fires when the counter would step from TIMEOUT-1 to TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] cnt;
  logic [3:0] shreg;
  logic       par_bit;
  logic [7:0] tcnt;
  logic       par_ok;
  logic       timeout_hit;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign par_ok = (par_bit == ^shreg);

  // A strobe on the expiry edge wins, so the timeout only fires on a bit_en=0 edge.
  assign timeout_hit = (state != IDLE) && !bus.bit_en && (tcnt == TO_LAST);

  // Frame FSM, stall timer and registered outputs in one sequential block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      shreg     <= 4'h0;
      par_bit   <= 1'b0;
      tcnt      <= 8'd0;
      bus.D     <= 4'h0;
      bus.ld    <= 1'b0;
      bus.busy  <= 1'b0;
      bus.perr  <= 1'b0;
      bus.ferr  <= 1'b0;
    end else begin
      // Status flags are single-cycle pulses.
      bus.ld   <= 1'b0;
      bus.perr <= 1'b0;
      bus.ferr <= 1'b0;

      // Stall timer only runs while a frame is open and the line is quiet.
      if (state == IDLE || bus.bit_en) begin
        tcnt <= 8'd0;
      end else begin
        tcnt <= tcnt + 8'd1;
      end

      if (timeout_hit) begin
        // Drop the partial frame; D keeps its last accepted value.
        state    <= IDLE;
        bus.busy <= 1'b0;
        bus.ferr <= 1'b1;
        cnt      <= 2'd0;
        shreg    <= 4'h0;
        tcnt     <= 8'd0;
      end else if (bus.bit_en) begin
        case (state)
          IDLE: begin
            // A 1 on the line is idle; only a 0 opens a frame.
            if (!bus.sin) begin
              state    <= DATA;
              cnt      <= 2'd0;
              bus.busy <= 1'b1;
            end
          end
          DATA: begin
            // LSB first: strobe n lands in bit n.
            shreg[cnt] <= bus.sin;
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= PAR;
            end
          end
          PAR: begin
            par_bit <= bus.sin;
            state   <= STOP;
          end
          STOP: begin
            // IDLE is re-entered here so a start bit on the very next strobe is taken.
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (bus.sin) begin
              if (par_ok) begin
                bus.D  <= shreg;
                bus.ld <= 1'b1;
              end else begin
                bus.perr <= 1'b1;
              end
            end else begin
              bus.ferr <= 1'b1;
              bus.perr <= !par_ok;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Bench for serial_nibble_rx: table of back-to-back frames plus timeout, strobe-on-expiry and async reset sequences.
// Every ld/perr/ferr pulse is matched against a queue of expected events.
module tb_serial_nibble_rx;

  logic clk;
  logic rst;

  serial_nibble_rx_if bus ();

  serial_nibble_rx #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       ld;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [3:0] nib;
    logic       par;
    logic       stop;
    logic [3:0] exp_d;
    logic       exp_ld;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Any flag pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (bus.ld || bus.perr || bus.ferr)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got D=%h ld=%b perr=%b ferr=%b, none expected",
                 bus.D, bus.ld, bus.perr, bus.ferr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.D !== e.d || bus.ld !== e.ld || bus.perr !== e.perr || bus.ferr !== e.ferr) begin
          failures++;
          $display("FAIL event got D=%h ld=%b perr=%b ferr=%b, expected D=%h ld=%b perr=%b ferr=%b",
                   bus.D, bus.ld, bus.perr, bus.ferr, e.d, e.ld, e.perr, e.ferr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] mk(input logic [3:0] nib, input logic par, input logic stop);
    return {stop, par, nib, 1'b0};
  endfunction

  // Drives the first n strobes of a frame; gap_len quiet cycles go in before strobe gap_pos.
  task automatic drive_bits(input logic [6:0] seq, input int n, input int gap_pos, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_pos) begin
        bus.bit_en = 1'b0;
        repeat (gap_len) tick();
      end
      bus.bit_en = 1'b1;
      bus.sin    = seq[i];
      tick();
    end
  endtask

  task automatic push(input logic [3:0] d, input logic ld, input logic perr, input logic ferr);
    exp_t e;
    e.d = d; e.ld = ld; e.perr = perr; e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  vec_t vecs[8];

  initial begin
    // nib, parity bit sent, stop bit sent, expected D, ld, perr, ferr
    vecs[0] = '{4'hA, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h7, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'h3, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'h3, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'hF, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'h1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'h6, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0};

    rst        = 1'b0;
    bus.bit_en = 1'b0;
    bus.sin    = 1'b1;
    repeat (2) tick();

    chk("reset_D", bus.D, 4'h0);
    chk("reset_ld", {3'b0, bus.ld}, 4'h0);
    chk("reset_busy", {3'b0, bus.busy}, 4'h0);
    chk("reset_perr", {3'b0, bus.perr}, 4'h0);
    chk("reset_ferr", {3'b0, bus.ferr}, 4'h0);

    rst = 1'b1;
    tick();

    // Idle-line strobes must not open a frame.
    bus.bit_en = 1'b1;
    bus.sin    = 1'b1;
    repeat (3) tick();
    chk("idle_busy", {3'b0, bus.busy}, 4'h0);

    // Back-to-back frames with bit_en held high.
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].exp_d, vecs[i].exp_ld, vecs[i].exp_perr, vecs[i].exp_ferr);
      drive_bits(mk(vecs[i].nib, vecs[i].par, vecs[i].stop), 7, 7, 0);
    end
    bus.bit_en = 1'b0;
    tick();
    chk("table_final_D", bus.D, 4'h6);
    chk("table_final_busy", {3'b0, bus.busy}, 4'h0);

    // Timeout: start + 2 data bits, then a stalled line.
    drive_bits(mk(4'h2, 1'b1, 1'b1), 3, 7, 0);
    bus.bit_en = 1'b0;
    repeat (15) tick();
    chk("to_busy_before", {3'b0, bus.busy}, 4'h1);
    chk("to_ferr_before", {3'b0, bus.ferr}, 4'h0);
    push(4'h6, 1'b0, 1'b0, 1'b1);
    tick();
    chk("to_busy_after", {3'b0, bus.busy}, 4'h0);
    chk("to_ferr_after", {3'b0, bus.ferr}, 4'h1);
    tick();
    chk("to_ferr_drop", {3'b0, bus.ferr}, 4'h0);
    chk("to_D_kept", bus.D, 4'h6);

    push(4'h5, 1'b1, 1'b0, 1'b0);
    drive_bits(mk(4'h5, 1'b0, 1'b1), 7, 7, 0);
    bus.bit_en = 1'b0;
    tick();
    chk("after_to_D", bus.D, 4'h5);

    // Strobe lands on the would-be timeout edge: frame must survive.
    push(4'h9, 1'b1, 1'b0, 1'b0);
    drive_bits(mk(4'h9, 1'b0, 1'b1), 7, 3, 15);
    bus.bit_en = 1'b0;
    tick();
    chk("edge_strobe_D", bus.D, 4'h9);

    // Async reset while waiting in PAR.
    drive_bits(mk(4'hC, 1'b0, 1'b1), 5, 7, 0);
    bus.bit_en = 1'b0;
    chk("par_busy", {3'b0, bus.busy}, 4'h1);
    rst = 1'b0;
    #1;
    chk("arst_D", bus.D, 4'h0);
    chk("arst_busy", {3'b0, bus.busy}, 4'h0);
    chk("arst_ld", {3'b0, bus.ld}, 4'h0);
    chk("arst_perr", {3'b0, bus.perr}, 4'h0);
    chk("arst_ferr", {3'b0, bus.ferr}, 4'h0);
    tick();
    rst = 1'b1;
    tick();

    push(4'hC, 1'b1, 1'b0, 1'b0);
    drive_bits(mk(4'hC, 1'b0, 1'b1), 7, 7, 0);
    bus.bit_en = 1'b0;
    repeat (3) tick();
    chk("post_rst_D", bus.D, 4'hC);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d outstanding expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
